// File: rtl/accelerator_weighting_arbiter.sv
// Round-robin arbiter sharing one matrix-product engine between the forward and
// backward weighting requesters, with operand/result routing and a BUSY watchdog.
module accelerator_weighting_arbiter #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 F_REQ,
    input  logic                 B_REQ,
    output logic                 F_GNT,
    output logic                 B_GNT,
    output logic                 F_DONE,
    output logic                 B_DONE,
    output logic                 ERROR,

    input  logic                 F_A_I_ENABLE,
    input  logic                 F_A_J_ENABLE,
    input  logic                 F_B_I_ENABLE,
    input  logic                 F_B_J_ENABLE,
    input  logic [DATA_SIZE-1:0] F_A_IN,
    input  logic [DATA_SIZE-1:0] F_B_IN,
    output logic                 F_OUT_I_ENABLE,
    output logic                 F_OUT_J_ENABLE,

    input  logic                 B_A_I_ENABLE,
    input  logic                 B_A_J_ENABLE,
    input  logic                 B_B_I_ENABLE,
    input  logic                 B_B_J_ENABLE,
    input  logic [DATA_SIZE-1:0] B_A_IN,
    input  logic [DATA_SIZE-1:0] B_B_IN,
    output logic                 B_OUT_I_ENABLE,
    output logic                 B_OUT_J_ENABLE,

    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,

    output logic                 ENG_START,
    input  logic                 ENG_READY,
    output logic                 ENG_A_I_ENABLE,
    output logic                 ENG_A_J_ENABLE,
    output logic                 ENG_B_I_ENABLE,
    output logic                 ENG_B_J_ENABLE,
    output logic [DATA_SIZE-1:0] ENG_SIZE_A_I,
    output logic [DATA_SIZE-1:0] ENG_SIZE_A_J,
    output logic [DATA_SIZE-1:0] ENG_SIZE_B_I,
    output logic [DATA_SIZE-1:0] ENG_SIZE_B_J,
    output logic [DATA_SIZE-1:0] ENG_A_IN,
    output logic [DATA_SIZE-1:0] ENG_B_IN,
    input  logic                 ENG_OUT_I_ENABLE,
    input  logic                 ENG_OUT_J_ENABLE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] TIMEOUT_C = CONTROL_SIZE'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [1:0]              gnt_q, gnt_d;       // [0] = forward, [1] = backward
    logic                    last_b_q, last_b_d;
    logic                    error_q, error_d;
    logic [CONTROL_SIZE-1:0] wdog_q, wdog_d;
    logic [CONTROL_SIZE-1:0] wdog_inc;
    logic [DATA_SIZE-1:0]    size_a_i_q, size_a_i_d;
    logic [DATA_SIZE-1:0]    size_a_j_q, size_a_j_d;
    logic [DATA_SIZE-1:0]    size_b_i_q, size_b_i_d;
    logic [DATA_SIZE-1:0]    size_b_j_q, size_b_j_d;

    assign wdog_inc = wdog_q + CONTROL_SIZE'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt_q      <= '0;
            last_b_q   <= 1'b1;
            error_q    <= 1'b0;
            wdog_q     <= '0;
            size_a_i_q <= '0;
            size_a_j_q <= '0;
            size_b_i_q <= '0;
            size_b_j_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            last_b_q   <= last_b_d;
            error_q    <= error_d;
            wdog_q     <= wdog_d;
            size_a_i_q <= size_a_i_d;
            size_a_j_q <= size_a_j_d;
            size_b_i_q <= size_b_i_d;
            size_b_j_q <= size_b_j_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_b_d   = last_b_q;
        error_d    = 1'b0;
        wdog_d     = wdog_q;
        size_a_i_d = size_a_i_q;
        size_a_j_d = size_a_j_q;
        size_b_i_d = size_b_i_q;
        size_b_j_d = size_b_j_q;
        case (state_q)
            ST_IDLE: begin
                if (F_REQ || B_REQ) begin
                    if (F_REQ && (!B_REQ || last_b_q)) begin
                        gnt_d = 2'b01;
                    end else begin
                        gnt_d = 2'b10;
                    end
                    // Sizes are captured on entry to GRANT so they are stable alongside ENG_START.
                    size_a_i_d = SIZE_N_IN;
                    size_a_j_d = SIZE_N_IN;
                    size_b_i_d = SIZE_R_IN;
                    size_b_j_d = SIZE_N_IN;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                wdog_d  = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (ENG_READY) begin
                    state_d = ST_RELEASE;
                end else if (wdog_inc == TIMEOUT_C) begin
                    error_d  = 1'b1;
                    gnt_d    = '0;
                    last_b_d = gnt_q[1];
                    state_d  = ST_IDLE;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            ST_RELEASE: begin
                gnt_d    = '0;
                last_b_d = gnt_q[1];
                state_d  = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        F_GNT          = gnt_q[0];
        B_GNT          = gnt_q[1];
        ERROR          = error_q;
        ENG_START      = (state_q == ST_GRANT);
        F_DONE         = (state_q == ST_RELEASE) && gnt_q[0];
        B_DONE         = (state_q == ST_RELEASE) && gnt_q[1];
        ENG_SIZE_A_I   = size_a_i_q;
        ENG_SIZE_A_J   = size_a_j_q;
        ENG_SIZE_B_I   = size_b_i_q;
        ENG_SIZE_B_J   = size_b_j_q;
        ENG_A_I_ENABLE = 1'b0;
        ENG_A_J_ENABLE = 1'b0;
        ENG_B_I_ENABLE = 1'b0;
        ENG_B_J_ENABLE = 1'b0;
        ENG_A_IN       = '0;
        ENG_B_IN       = '0;
        if (state_q == ST_BUSY) begin
            if (gnt_q[0]) begin
                ENG_A_I_ENABLE = F_A_I_ENABLE;
                ENG_A_J_ENABLE = F_A_J_ENABLE;
                ENG_B_I_ENABLE = F_B_I_ENABLE;
                ENG_B_J_ENABLE = F_B_J_ENABLE;
                ENG_A_IN       = F_A_IN;
                ENG_B_IN       = F_B_IN;
            end else if (gnt_q[1]) begin
                ENG_A_I_ENABLE = B_A_I_ENABLE;
                ENG_A_J_ENABLE = B_A_J_ENABLE;
                ENG_B_I_ENABLE = B_B_I_ENABLE;
                ENG_B_J_ENABLE = B_B_J_ENABLE;
                ENG_A_IN       = B_A_IN;
                ENG_B_IN       = B_B_IN;
            end
        end
        F_OUT_I_ENABLE = ENG_OUT_I_ENABLE && gnt_q[0];
        F_OUT_J_ENABLE = ENG_OUT_J_ENABLE && gnt_q[0];
        B_OUT_I_ENABLE = ENG_OUT_I_ENABLE && gnt_q[1];
        B_OUT_J_ENABLE = ENG_OUT_J_ENABLE && gnt_q[1];
    end

endmodule

// File: tb/tb_accelerator_weighting_arbiter.sv
// Directed bench for accelerator_weighting_arbiter: grant/release, round robin,
// routing isolation, watchdog abort, async reset and size latching.
module tb_accelerator_weighting_arbiter;

    localparam int unsigned DW = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic          F_REQ, B_REQ, F_GNT, B_GNT, F_DONE, B_DONE, ERROR;
    logic          F_A_I_ENABLE, F_A_J_ENABLE, F_B_I_ENABLE, F_B_J_ENABLE;
    logic          B_A_I_ENABLE, B_A_J_ENABLE, B_B_I_ENABLE, B_B_J_ENABLE;
    logic [DW-1:0] F_A_IN, F_B_IN, B_A_IN, B_B_IN;
    logic          F_OUT_I_ENABLE, F_OUT_J_ENABLE, B_OUT_I_ENABLE, B_OUT_J_ENABLE;
    logic [DW-1:0] SIZE_R_IN, SIZE_N_IN;
    logic          ENG_START, ENG_READY;
    logic          ENG_A_I_ENABLE, ENG_A_J_ENABLE, ENG_B_I_ENABLE, ENG_B_J_ENABLE;
    logic [DW-1:0] ENG_SIZE_A_I, ENG_SIZE_A_J, ENG_SIZE_B_I, ENG_SIZE_B_J;
    logic [DW-1:0] ENG_A_IN, ENG_B_IN;
    logic          ENG_OUT_I_ENABLE, ENG_OUT_J_ENABLE;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_b;

    accelerator_weighting_arbiter #(
        .DATA_SIZE   (DW),
        .CONTROL_SIZE(64),
        .TIMEOUT     (8)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .F_REQ           (F_REQ),
        .B_REQ           (B_REQ),
        .F_GNT           (F_GNT),
        .B_GNT           (B_GNT),
        .F_DONE          (F_DONE),
        .B_DONE          (B_DONE),
        .ERROR           (ERROR),
        .F_A_I_ENABLE    (F_A_I_ENABLE),
        .F_A_J_ENABLE    (F_A_J_ENABLE),
        .F_B_I_ENABLE    (F_B_I_ENABLE),
        .F_B_J_ENABLE    (F_B_J_ENABLE),
        .F_A_IN          (F_A_IN),
        .F_B_IN          (F_B_IN),
        .F_OUT_I_ENABLE  (F_OUT_I_ENABLE),
        .F_OUT_J_ENABLE  (F_OUT_J_ENABLE),
        .B_A_I_ENABLE    (B_A_I_ENABLE),
        .B_A_J_ENABLE    (B_A_J_ENABLE),
        .B_B_I_ENABLE    (B_B_I_ENABLE),
        .B_B_J_ENABLE    (B_B_J_ENABLE),
        .B_A_IN          (B_A_IN),
        .B_B_IN          (B_B_IN),
        .B_OUT_I_ENABLE  (B_OUT_I_ENABLE),
        .B_OUT_J_ENABLE  (B_OUT_J_ENABLE),
        .SIZE_R_IN       (SIZE_R_IN),
        .SIZE_N_IN       (SIZE_N_IN),
        .ENG_START       (ENG_START),
        .ENG_READY       (ENG_READY),
        .ENG_A_I_ENABLE  (ENG_A_I_ENABLE),
        .ENG_A_J_ENABLE  (ENG_A_J_ENABLE),
        .ENG_B_I_ENABLE  (ENG_B_I_ENABLE),
        .ENG_B_J_ENABLE  (ENG_B_J_ENABLE),
        .ENG_SIZE_A_I    (ENG_SIZE_A_I),
        .ENG_SIZE_A_J    (ENG_SIZE_A_J),
        .ENG_SIZE_B_I    (ENG_SIZE_B_I),
        .ENG_SIZE_B_J    (ENG_SIZE_B_J),
        .ENG_A_IN        (ENG_A_IN),
        .ENG_B_IN        (ENG_B_IN),
        .ENG_OUT_I_ENABLE(ENG_OUT_I_ENABLE),
        .ENG_OUT_J_ENABLE(ENG_OUT_J_ENABLE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        RST = 1'b0;
        F_REQ = 1'b0; B_REQ = 1'b0; ENG_READY = 1'b0;
        F_A_I_ENABLE = 1'b0; F_A_J_ENABLE = 1'b0; F_B_I_ENABLE = 1'b0; F_B_J_ENABLE = 1'b0;
        B_A_I_ENABLE = 1'b0; B_A_J_ENABLE = 1'b0; B_B_I_ENABLE = 1'b0; B_B_J_ENABLE = 1'b0;
        F_A_IN = '0; F_B_IN = '0; B_A_IN = '0; B_B_IN = '0;
        SIZE_R_IN = '0; SIZE_N_IN = '0;
        ENG_OUT_I_ENABLE = 1'b0; ENG_OUT_J_ENABLE = 1'b0;

        // Reset state
        #3;
        chk("rst_f_gnt", F_GNT, 0);
        chk("rst_b_gnt", B_GNT, 0);
        chk("rst_start", ENG_START, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_f_done", F_DONE, 0);
        chk("rst_size_a_i", ENG_SIZE_A_I, 0);
        chk("rst_size_b_i", ENG_SIZE_B_I, 0);
        @(negedge CLK);
        RST = 1'b1;

        // Single forward operation, R=2 N=4
        SIZE_R_IN = 64'd2; SIZE_N_IN = 64'd4; F_REQ = 1'b1;
        tick();
        chk("op1_f_gnt", F_GNT, 1);
        chk("op1_b_gnt", B_GNT, 0);
        chk("op1_start", ENG_START, 1);
        chk("op1_size_a_i", ENG_SIZE_A_I, 4);
        chk("op1_size_a_j", ENG_SIZE_A_J, 4);
        chk("op1_size_b_i", ENG_SIZE_B_I, 2);
        chk("op1_size_b_j", ENG_SIZE_B_J, 4);
        F_REQ = 1'b0;
        tick();
        chk("op1_busy_start", ENG_START, 0);
        chk("op1_busy_gnt", F_GNT, 1);
        F_A_I_ENABLE = 1'b1; F_A_IN = 64'h1234; B_A_IN = 64'hDEAD;
        #1;
        chk("op1_a_i_en", ENG_A_I_ENABLE, 1);
        chk("op1_a_in", ENG_A_IN, 64'h1234);
        ENG_READY = 1'b1;
        tick();
        chk("op1_f_done", F_DONE, 1);
        chk("op1_b_done", B_DONE, 0);
        chk("op1_rel_gnt", F_GNT, 1);
        chk("op1_rel_a_in", ENG_A_IN, 0);
        ENG_READY = 1'b0; F_A_I_ENABLE = 1'b0;
        tick();
        chk("op1_idle_done", F_DONE, 0);
        chk("op1_idle_gnt", F_GNT, 0);

        // Both requesting: forward was served last, so backward leads the alternation
        F_REQ = 1'b1; B_REQ = 1'b1; F_A_IN = '0; B_A_IN = 64'hB0B0;
        for (int k = 0; k < 4; k++) begin
            exp_b = (k % 2 == 0);
            tick();
            chk("rr_b_gnt", B_GNT, exp_b);
            chk("rr_f_gnt", F_GNT, !exp_b);
            tick();
            if (exp_b) begin
                ENG_OUT_I_ENABLE = 1'b1; F_A_IN = 64'hFFFF_FFFF;
                #1;
                chk("route_b_out_i", B_OUT_I_ENABLE, 1);
                chk("route_f_out_i", F_OUT_I_ENABLE, 0);
                chk("route_a_in", ENG_A_IN, 64'hB0B0);
                ENG_OUT_I_ENABLE = 1'b0; F_A_IN = 64'h5555;
                #1;
                chk("route_b_out_i_low", B_OUT_I_ENABLE, 0);
                chk("route_a_in_2", ENG_A_IN, 64'hB0B0);
            end
            ENG_READY = 1'b1;
            tick();
            chk("rr_b_done", B_DONE, exp_b);
            chk("rr_f_done", F_DONE, !exp_b);
            ENG_READY = 1'b0;
            if (k == 3) begin
                F_REQ = 1'b0; B_REQ = 1'b0;
            end
            tick();
        end

        // Watchdog abort after 8 BUSY cycles
        F_REQ = 1'b1;
        tick();
        chk("wd_gnt", F_GNT, 1);
        F_REQ = 1'b0;
        tick();
        repeat (7) tick();
        chk("wd_busy8_gnt", F_GNT, 1);
        chk("wd_busy8_err", ERROR, 0);
        tick();
        chk("wd_error", ERROR, 1);
        chk("wd_gnt_drop", F_GNT, 0);
        chk("wd_no_done", F_DONE, 0);
        chk("wd_no_start", ENG_START, 0);
        tick();
        chk("wd_error_pulse", ERROR, 0);
        chk("wd_idle_gnt", F_GNT, 0);

        // Async reset during BUSY with backward waiting
        F_REQ = 1'b1;
        tick();
        F_REQ = 1'b0;
        tick();
        F_A_I_ENABLE = 1'b1; B_REQ = 1'b1;
        #1;
        chk("ar_pre_a_i_en", ENG_A_I_ENABLE, 1);
        #1;
        RST = 1'b0;
        #1;
        chk("ar_f_gnt", F_GNT, 0);
        chk("ar_a_i_en", ENG_A_I_ENABLE, 0);
        chk("ar_size_a_i", ENG_SIZE_A_I, 0);
        chk("ar_size_b_i", ENG_SIZE_B_I, 0);
        chk("ar_start", ENG_START, 0);
        chk("ar_done", F_DONE, 0);
        F_A_I_ENABLE = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        chk("ar_b_gnt", B_GNT, 1);
        chk("ar_b_f_gnt", F_GNT, 0);
        chk("ar_b_size_b_i", ENG_SIZE_B_I, 2);
        B_REQ = 1'b0;
        tick();
        ENG_READY = 1'b1;
        tick();
        chk("ar_b_done", B_DONE, 1);
        chk("ar_b_f_done", F_DONE, 0);
        ENG_READY = 1'b0;
        tick();

        // ENG_READY in IDLE ignored; size change after GRANT ignored
        ENG_READY = 1'b1;
        tick();
        chk("ir_f_gnt", F_GNT, 0);
        chk("ir_b_gnt", B_GNT, 0);
        chk("ir_start", ENG_START, 0);
        chk("ir_b_done", B_DONE, 0);
        chk("ir_size_a_i", ENG_SIZE_A_I, 4);
        ENG_READY = 1'b0;
        SIZE_R_IN = 64'd3; SIZE_N_IN = 64'd6; F_REQ = 1'b1;
        tick();
        chk("sz_gnt", F_GNT, 1);
        chk("sz_size_a_i", ENG_SIZE_A_I, 6);
        chk("sz_size_b_i", ENG_SIZE_B_I, 3);
        F_REQ = 1'b0; SIZE_N_IN = 64'd9; SIZE_R_IN = 64'd7;
        tick();
        chk("sz_busy_a_i", ENG_SIZE_A_I, 6);
        chk("sz_busy_a_j", ENG_SIZE_A_J, 6);
        chk("sz_busy_b_i", ENG_SIZE_B_I, 3);
        chk("sz_busy_b_j", ENG_SIZE_B_J, 6);
        tick();
        chk("sz_busy2_a_i", ENG_SIZE_A_I, 6);
        ENG_READY = 1'b1;
        tick();
        chk("sz_f_done", F_DONE, 1);
        ENG_READY = 1'b0;
        tick();
        chk("sz_idle_gnt", F_GNT, 0);
        chk("sz_idle_size_b_j", ENG_SIZE_B_J, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
